// File: rtl/external_call_fifo_pkg.sv
// Shared helpers for the external_call_fifo show-ahead call queue.
package external_call_fifo_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned DEFAULT_DEPTH = 8;
    localparam int unsigned DEFAULT_SLACK = 2;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Wraps at DEPTH-1, not at a power-of-two boundary.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/external_call_fifo_mem.sv
// DEPTH x WIDTH flop array: one synchronous write port, one asynchronous read port, no reset.
module external_call_fifo_mem #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PW    = 3
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [PW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [PW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/external_call_fifo.sv
// Show-ahead call queue feeding an external method's rden/empty argument port.
module external_call_fifo
    import external_call_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned SLACK = DEFAULT_SLACK
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enq_valid_in,
    input  logic [WIDTH-1:0]           enq_data_in,
    output logic                       enq_rdy_out,
    input  logic                       deq_rden_in,
    output logic [WIDTH-1:0]           deq_data_out,
    output logic                       deq_empty_out,
    output logic [$clog2(DEPTH+1)-1:0] count_out,
    output logic                       overflow_out,
    output logic                       underflow_out
);

    localparam int unsigned PW = ptr_width(DEPTH);
    localparam int unsigned CW = cnt_width(DEPTH);

    logic [PW-1:0]    wp_q, rp_q;
    logic [CW-1:0]    count_q, count_d;
    logic             empty_q, rdy_q, ovf_q, udf_q;
    logic             push, pop;
    logic [WIDTH-1:0] rd_data;

    assign pop     = deq_rden_in & (count_q != '0);
    assign push    = enq_valid_in & ((32'(count_q) < DEPTH) | pop);
    assign count_d = count_q + CW'(push) - CW'(pop);

    external_call_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_mem (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wp_q),
        .wdata_i (enq_data_in),
        .raddr_i (rp_q),
        .rdata_o (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            rdy_q   <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            if (push) begin
                wp_q <= PW'(ptr_inc(32'(wp_q), DEPTH));
            end
            if (pop) begin
                rp_q <= PW'(ptr_inc(32'(rp_q), DEPTH));
            end
            count_q <= count_d;
            empty_q <= (count_d == '0);
            // Ready looks at post-update occupancy so the caller's in-flight words still fit.
            rdy_q   <= (DEPTH - 32'(count_d)) > SLACK;
            if (enq_valid_in && !push) begin
                ovf_q <= 1'b1;
            end
            if (deq_rden_in && count_q == '0) begin
                udf_q <= 1'b1;
            end
        end
    end

    assign enq_rdy_out   = rdy_q;
    assign deq_empty_out = empty_q;
    assign deq_data_out  = empty_q ? '0 : rd_data;
    assign count_out     = count_q;
    assign overflow_out  = ovf_q;
    assign underflow_out = udf_q;

endmodule

// File: tb/tb_external_call_fifo.sv
// Directed plus randomized bench for external_call_fifo against a queue-based reference model.
module tb_external_call_fifo;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned SLACK = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             enq_valid;
    logic [WIDTH-1:0] enq_data;
    logic             enq_rdy;
    logic             deq_rden;
    logic [WIDTH-1:0] deq_data;
    logic             deq_empty;
    logic [3:0]       count;
    logic             ovf;
    logic             udf;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [WIDTH-1:0] mq[$];
    logic             m_rdy, m_ovf, m_udf;

    always #5 clk = ~clk;

    external_call_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .SLACK (SLACK)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enq_valid_in  (enq_valid),
        .enq_data_in   (enq_data),
        .enq_rdy_out   (enq_rdy),
        .deq_rden_in   (deq_rden),
        .deq_data_out  (deq_data),
        .deq_empty_out (deq_empty),
        .count_out     (count),
        .overflow_out  (ovf),
        .underflow_out (udf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [31:0] exp_data;
        exp_data = (mq.size() == 0) ? 32'h0 : mq[0];
        chk("count", 32'(count), mq.size());
        chk("empty", 32'(deq_empty), 32'(mq.size() == 0));
        chk("data", deq_data, exp_data);
        chk("rdy", 32'(enq_rdy), 32'(m_rdy));
        chk("overflow", 32'(ovf), 32'(m_ovf));
        chk("underflow", 32'(udf), 32'(m_udf));
    endtask

    task automatic model_update(input logic v, input logic [31:0] d, input logic r);
        int unsigned sz;
        logic        pop_m, push_m;
        sz     = mq.size();
        pop_m  = r && (sz != 0);
        push_m = v && ((sz < DEPTH) || pop_m);
        if (pop_m) mq.delete(0);
        if (push_m) mq.push_back(d);
        if (v && !push_m) m_ovf = 1'b1;
        if (r && sz == 0) m_udf = 1'b1;
        m_rdy = (DEPTH - mq.size()) > SLACK;
    endtask

    task automatic step(input logic v, input logic [31:0] d, input logic r);
        rst = 1'b0; enq_valid = v; enq_data = d; deq_rden = r;
        @(posedge clk);
        model_update(v, d, r);
        #1;
        check_all();
    endtask

    task automatic reset_cycle();
        rst = 1'b1; enq_valid = 1'b0; enq_data = '0; deq_rden = 1'b0;
        @(posedge clk);
        mq.delete();
        m_rdy = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
        #1;
        check_all();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset and idle
        reset_cycle();
        reset_cycle();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0, 1'b0);
            chk("rdy_after_reset", 32'(enq_rdy), 32'h1);
        end

        // Single enqueue then read
        step(1'b1, 32'h1234, 1'b0);
        chk("head_1234", deq_data, 32'h1234);
        step(1'b0, 32'h0, 1'b1);
        chk("empty_after_pop", 32'(deq_empty), 32'h1);

        // Fill 1..9 without reads
        for (int i = 1; i <= 9; i++) begin
            step(1'b1, 32'(i), 1'b0);
            if (i == 6) chk("rdy_falls_6th", 32'(enq_rdy), 32'h0);
            if (i == 8) chk("ovf_clear_8th", 32'(ovf), 32'h0);
        end
        chk("count_full", 32'(count), 32'h8);
        chk("ovf_9th", 32'(ovf), 32'h1);
        chk("head_still_1", deq_data, 32'h1);

        // Enqueue with same-cycle pop at full, then drain
        step(1'b1, 32'hAA, 1'b1);
        chk("count_full_swap", 32'(count), 32'h8);
        for (int i = 2; i <= 8; i++) begin
            chk("drain_seq", deq_data, 32'(i));
            step(1'b0, 32'h0, 1'b1);
        end
        chk("drain_last", deq_data, 32'hAA);
        step(1'b0, 32'h0, 1'b1);

        // Full-rate streaming
        reset_cycle();
        step(1'b1, 32'h0, 1'b0);
        for (int i = 1; i < 20; i++) begin
            chk("stream_head", deq_data, 32'(i - 1));
            step(1'b1, 32'(i), 1'b1);
            chk("stream_count", 32'(count), 32'h1);
        end
        step(1'b0, 32'h0, 1'b1);

        // Underflow, then mid-operation reset
        step(1'b0, 32'h0, 1'b1);
        chk("udf_set", 32'(udf), 32'h1);
        for (int i = 0; i < 5; i++) step(1'b1, 32'hC0DE_0000 + 32'(i), 1'b0);
        reset_cycle();
        chk("count_after_rst", 32'(count), 32'h0);
        step(1'b1, 32'h5555_AAAA, 1'b0);
        chk("head_new_data", deq_data, 32'h5555_AAAA);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 63) == 0) begin
                reset_cycle();
            end else begin
                step(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) == 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/external_call_fifo.md
# external_call_fifo

Show-ahead call queue that sits directly upstream of an external-class method using the FIFO-style `rden`/`empty` argument interface (e.g. an `Increment` or `Exec` port). It accepts argument words from the compiler-generated caller pipeline on a valid/ready handshake and presents them to the external module as head data with an empty flag. Almost-full backpressure leaves room for entries already in flight in the caller pipeline. Sticky error flags catch protocol violations on both sides.

## Interface
- `WIDTH`, 32: argument word width in bits (≥1).
- `DEPTH`, 8: number of entries (≥2; power of two not required).
- `SLACK`, 2: entries the caller may still issue after `enq_rdy_out` falls (0 ≤ SLACK < DEPTH).
- `clk`  in  1: sole clock.
- `rst`  in  1: synchronous, active-high reset.
- `enq_valid_in`  in  1: caller presents an argument word this cycle.
- `enq_data_in`  in  WIDTH: argument word.
- `enq_rdy_out`  out  1: caller may issue; registered almost-full inverse.
- `deq_rden_out`: not present. The external module drives `deq_rden_in`.
- `deq_rden_in`  in  1: external module consumes the head entry this cycle.
- `deq_data_out`  out  WIDTH: head entry; 0 whenever `deq_empty_out`=1.
- `deq_empty_out`  out  1: queue holds no entries.
- `count_out`  out  $clog2(DEPTH+1): current occupancy.
- `overflow_out`  out  1: sticky; an enqueue was dropped.
- `underflow_out`  out  1: sticky; `deq_rden_in` was asserted while empty.

## Operation
- Storage is a circular buffer with write pointer `wp` and read pointer `rp`, each $clog2(DEPTH) bits wide. A pointer wraps from DEPTH-1 to 0; it does not wrap at a power-of-two boundary.
- Define `push = enq_valid_in & (count<DEPTH | pop)` and `pop = deq_rden_in & (count!=0)`.
- On push: mem[wp] ← enq_data_in and wp advances. On pop: rp advances.
- Occupancy update: `count_next = count + push − pop`.
- Enqueue while full:
  - Without a same-cycle pop, the word is dropped, `overflow_out` is set and all state is otherwise unchanged.
  - With a same-cycle pop, the enqueue is accepted and count is unchanged.
- `deq_rden_in` while empty: no state change and `underflow_out` is set. A same-cycle enqueue is still accepted.
- Simultaneous push and pop at count=0 cannot occur, because pop requires count≠0.
- Show-ahead: `deq_data_out` = mem[rp], read combinationally, gated to 0 when empty.
- `enq_rdy_out` register ← `(DEPTH − count_next) > SLACK`.
- `enq_rdy_out` is advisory. Enqueues are accepted whenever space exists regardless of its value; only real overflow is an error.
- Sticky flags clear only on `rst`.

## Timing
- Reset values: `count_out`=0, `deq_empty_out`=1, `deq_data_out`=0, `enq_rdy_out`=0, `overflow_out`=0, `underflow_out`=0. Pointers are 0. Memory contents are not reset.
- `enq_rdy_out` rises in the first cycle after `rst` deasserts.
- Enqueue-to-visibility latency is 1 cycle: a word pushed in cycle N gives `deq_empty_out`=0 and valid `deq_data_out` in cycle N+1.
- `count_out` and `deq_empty_out` are registered from `count_next`.
- A pop in cycle N presents the next entry, or empty, in cycle N+1.
- Full-rate streaming is supported: 1 push and 1 pop per cycle indefinitely.
- `enq_rdy_out` reflects the occupancy after the current cycle's push and pop.
- `rst` asserted mid-operation discards all entries; reset values apply in the next cycle.
- The error flags assert in the cycle after the offending event.

## Structure
- Package `external_call_fifo_pkg` contains:
  - function `ptr_inc(ptr, depth)` for wrap-around increment;
  - localparam helpers for pointer and count widths.
- Sub-module `external_call_fifo_mem`: DEPTH×WIDTH flop array with one synchronous write port and one asynchronous read port, no reset.
- Top level holds the pointers, count, ready register, flags and output gating.

## Test plan
All scenarios use WIDTH=32, DEPTH=8, SLACK=2.
- Reset, then idle 3 cycles → `count_out`=0, `deq_empty_out`=1, `deq_data_out`=0, both flags 0, `enq_rdy_out`=1 from the first post-reset cycle.
- Enqueue 0x1234 in cycle 0 → in cycle 1, `deq_empty_out`=0, `deq_data_out`=0x1234, `count_out`=1. Pulse `rden` in cycle 1 → in cycle 2, empty=1, data=0, count=0.
- Back-to-back enqueue of 1..9 with no reads:
  - `enq_rdy_out` falls after the 6th push;
  - the 7th and 8th pushes are accepted (count=8, overflow=0);
  - the 9th push sets `overflow_out`, count stays 8, and the head remains 1.
- At count=8 (head 1), assert enqueue 0xAA together with `rden` → count stays 8. Draining yields 2..8 then 0xAA; `overflow_out` is unchanged.
- Stream 0..19 with push and pop every cycle after the first → output sequence 0..19 in order with pointers wrapping twice, count stays 1, and no flags are set.
- Pulse `rden` while empty → `underflow_out`=1, count=0. Fill to 5, then assert `rst` for 1 cycle → count=0, empty=1, both flags 0, and the head is not the old data after a new enqueue.
